// File: rtl/start_token_fifo_ctrl_pkg.sv
// Shared helpers for the start-token FIFO: ap_fifo handshake qualifiers and
// occupancy width derivation.
package start_token_fifo_ctrl_pkg;

  // Occupancy needs one bit more than the SRL address to represent DEPTH.
  function automatic int occ_w(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic logic push_ok(input logic wr, input logic ce, input logic full_n);
    return wr & ce & full_n;
  endfunction

  function automatic logic pop_ok(input logic rd, input logic ce, input logic empty_n);
    return rd & ce & empty_n;
  endfunction

endpackage

// File: rtl/start_token_srl.sv
// DEPTH-entry shift-register storage: newest entry at index 0, oldest at the
// highest occupied index. Contents are not reset.
module start_token_srl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/start_token_fifo_ctrl.sv
// ap_fifo control wrapper around the start-token SRL: occupancy, registered
// full/empty flags and fall-through read addressing.
module start_token_fifo_ctrl
  import start_token_fifo_ctrl_pkg::*;
#(
  parameter  int DATA_WIDTH = 1,
  parameter  int ADDR_WIDTH = 1,
  parameter  int DEPTH      = 2,
  localparam int OCC_W      = occ_w(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [OCC_W-1:0]      if_num_data_valid,
  output logic [OCC_W-1:0]      if_fifo_cap
);

  logic [OCC_W-1:0]      cnt, cnt_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  push, pop;

  // Flags are registered, so push/pop qualify only on already-registered state.
  assign push = push_ok(if_write, if_write_ce, if_full_n);
  assign pop  = pop_ok(if_read, if_read_ce, if_empty_n);

  always_comb begin
    cnt_next = cnt;
    if (push && !pop)      cnt_next = cnt + OCC_W'(1);
    else if (pop && !push) cnt_next = cnt - OCC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      if_empty_n <= 1'b0;
      if_full_n  <= 1'b1;
    end else begin
      cnt        <= cnt_next;
      if_empty_n <= (cnt_next != '0);
      if_full_n  <= (cnt_next != OCC_W'(DEPTH));
    end
  end

  // Head sits at cnt-1; on push+pop the shift moves the next-oldest into it.
  assign addr = (cnt != '0) ? ADDR_WIDTH'(cnt - OCC_W'(1)) : '0;

  start_token_srl #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_srl (
    .clk (clk),
    .we  (push),
    .addr(addr),
    .din (if_din),
    .dout(if_dout)
  );

  assign if_num_data_valid = cnt;
  assign if_fifo_cap       = OCC_W'(DEPTH);

endmodule

// File: tb/tb_start_token_fifo_ctrl.sv
// Directed bench: table-driven vectors on a DEPTH=4 x 8-bit FIFO, plus a
// hand-written fill/drain sequence on a DEPTH=2 x 1-bit FIFO.
module tb_start_token_fifo_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // DEPTH=2, DATA_WIDTH=1
  logic       a_reset, a_full_n, a_wce, a_wr, a_din, a_empty_n, a_rce, a_rd, a_dout;
  logic [1:0] a_num, a_cap;

  start_token_fifo_ctrl #(.DATA_WIDTH(1), .ADDR_WIDTH(1), .DEPTH(2)) u_a (
    .clk(clk), .reset(a_reset), .if_full_n(a_full_n), .if_write_ce(a_wce),
    .if_write(a_wr), .if_din(a_din), .if_empty_n(a_empty_n), .if_read_ce(a_rce),
    .if_read(a_rd), .if_dout(a_dout), .if_num_data_valid(a_num), .if_fifo_cap(a_cap)
  );

  // DEPTH=4, DATA_WIDTH=8
  logic       b_reset, b_full_n, b_wce, b_wr, b_empty_n, b_rce, b_rd;
  logic [7:0] b_din, b_dout;
  logic [2:0] b_num, b_cap;

  start_token_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) u_b (
    .clk(clk), .reset(b_reset), .if_full_n(b_full_n), .if_write_ce(b_wce),
    .if_write(b_wr), .if_din(b_din), .if_empty_n(b_empty_n), .if_read_ce(b_rce),
    .if_read(b_rd), .if_dout(b_dout), .if_num_data_valid(b_num), .if_fifo_cap(b_cap)
  );

  typedef struct {
    logic       rst, wce, wr;
    logic [7:0] din;
    logic       rce, rd;
    logic       en, fn;
    int         cnt;
    logic [7:0] dout;
    logic       cd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic a_step(input logic rst, input logic wce, input logic wr, input logic din,
                        input logic rce, input logic rd);
    a_reset = rst; a_wce = wce; a_wr = wr; a_din = din; a_rce = rce; a_rd = rd;
    @(posedge clk); #1;
    a_reset = 0; a_wce = 0; a_wr = 0; a_rce = 0; a_rd = 0;
  endtask

  task automatic a_chk(input string tag, input logic en, input logic fn, input int cnt);
    chk({tag, " empty_n"}, int'(a_empty_n), int'(en));
    chk({tag, " full_n"},  int'(a_full_n),  int'(fn));
    chk({tag, " count"},   int'(a_num),     cnt);
  endtask

  initial begin
    a_reset = 1; a_wce = 0; a_wr = 0; a_din = 0; a_rce = 0; a_rd = 0;
    b_reset = 1; b_wce = 0; b_wr = 0; b_din = 0; b_rce = 0; b_rd = 0;

    //          rst wce wr din    rce rd  en fn cnt dout   cd
    tbl.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0}); // reset
    tbl.push_back('{0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0}); // idle
    tbl.push_back('{0, 1, 1, 8'hA5, 0, 0, 1, 1, 1, 8'hA5, 1}); // fall-through
    tbl.push_back('{0, 1, 1, 8'h3C, 0, 0, 1, 1, 2, 8'hA5, 1});
    tbl.push_back('{0, 1, 1, 8'h7E, 1, 1, 1, 1, 2, 8'h3C, 1}); // push+pop
    tbl.push_back('{0, 0, 0, 8'h00, 1, 1, 1, 1, 1, 8'h7E, 1});
    tbl.push_back('{0, 0, 1, 8'h11, 0, 0, 1, 1, 1, 8'h7E, 1}); // write, ce=0
    tbl.push_back('{0, 0, 0, 8'h00, 0, 1, 1, 1, 1, 8'h7E, 1}); // read, ce=0
    tbl.push_back('{0, 0, 0, 8'h00, 1, 1, 0, 1, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 1, 1, 0, 1, 0, 8'h00, 0}); // read empty
    tbl.push_back('{0, 1, 1, 8'h01, 0, 0, 1, 1, 1, 8'h01, 1});
    tbl.push_back('{0, 1, 1, 8'h02, 0, 0, 1, 1, 2, 8'h01, 1});
    tbl.push_back('{0, 1, 1, 8'h03, 0, 0, 1, 1, 3, 8'h01, 1});
    tbl.push_back('{0, 1, 1, 8'h04, 0, 0, 1, 0, 4, 8'h01, 1}); // full
    tbl.push_back('{0, 1, 1, 8'h55, 1, 1, 1, 1, 3, 8'h02, 1}); // pop only
    tbl.push_back('{0, 1, 1, 8'h66, 0, 0, 1, 0, 4, 8'h02, 1});
    tbl.push_back('{0, 0, 0, 8'h00, 1, 1, 1, 1, 3, 8'h03, 1});
    tbl.push_back('{1, 1, 1, 8'h99, 0, 0, 0, 1, 0, 8'h00, 0}); // reset w/ 3 queued
    tbl.push_back('{0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0});
    tbl.push_back('{0, 1, 1, 8'h42, 0, 0, 1, 1, 1, 8'h42, 1}); // 99 was dropped
    tbl.push_back('{0, 0, 0, 8'h00, 1, 1, 0, 1, 0, 8'h00, 0});

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      b_reset = tbl[i].rst; b_wce = tbl[i].wce; b_wr = tbl[i].wr; b_din = tbl[i].din;
      b_rce = tbl[i].rce; b_rd = tbl[i].rd;
      @(posedge clk); #1;
      chk($sformatf("v%0d empty_n", i), int'(b_empty_n), int'(tbl[i].en));
      chk($sformatf("v%0d full_n", i),  int'(b_full_n),  int'(tbl[i].fn));
      chk($sformatf("v%0d count", i),   int'(b_num),     tbl[i].cnt);
      chk($sformatf("v%0d cap", i),     int'(b_cap),     4);
      if (tbl[i].cd) chk($sformatf("v%0d dout", i), int'(b_dout), int'(tbl[i].dout));
    end
    b_reset = 0; b_wce = 0; b_wr = 0; b_rce = 0; b_rd = 0;

    // DEPTH=2 fill, overflow attempt, drain
    a_step(1, 0, 0, 0, 0, 0);
    a_chk("d2 reset", 0, 1, 0);
    chk("d2 cap", int'(a_cap), 2);
    a_step(0, 1, 1, 1, 0, 0);
    a_chk("d2 push1", 1, 1, 1);
    chk("d2 push1 dout", int'(a_dout), 1);
    a_step(0, 1, 1, 0, 0, 0);
    a_chk("d2 push0", 1, 0, 2);
    chk("d2 push0 dout", int'(a_dout), 1);
    a_step(0, 1, 1, 1, 0, 0);
    a_chk("d2 wr full", 1, 0, 2);
    chk("d2 wr full dout", int'(a_dout), 1);
    a_step(0, 0, 0, 0, 1, 1);
    a_chk("d2 pop1", 1, 1, 1);
    chk("d2 pop1 dout", int'(a_dout), 0);
    a_step(0, 0, 0, 0, 1, 1);
    a_chk("d2 pop0", 0, 1, 0);
    a_step(0, 0, 0, 0, 1, 1);
    a_chk("d2 rd empty", 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
